// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default geometry and the
// binary/Gray pointer conversions used on both sides of the clock crossing.
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_W = 4;
    localparam int unsigned FIFO_DEPTH  = 2 ** FIFO_ADDR_W;

    // Conversions work on a 32-bit container; callers zero-extend and truncate.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 31; i >= 0; i--) begin
            b[i] = (i == 31) ? g[i] : (b[i+1] ^ g[i]);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus entering the write clock domain.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] rq1;
    logic [WIDTH-1:0] rq2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= d;
            rq2 <= rq1;
        end
    end

    assign q = rq2;

endmodule

// File: rtl/fifo_wr_arbiter_ctrl.sv
// Write-side controller of the dual-clock FIFO: round-robin producer arbitration,
// write pointer maintenance and conservative full / almost-full flags.
module fifo_wr_arbiter_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = FIFO_ADDR_W,
    parameter int DATA_W   = 8,
    parameter int NREQ     = 4,
    parameter int AFULL_TH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] wdata_in,
    output logic [NREQ-1:0]        gnt,
    input  logic [ADDR_W:0]        rptr_gray,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_waddr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [ADDR_W:0]        wptr_gray,
    output logic                   wfull,
    output logic                   walmost_full
);

    localparam int PW    = ADDR_W + 1;
    localparam int IDX_W = $clog2(NREQ);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [PW-1:0]     wbin;
    logic [PW-1:0]     wbin_next;
    logic [PW-1:0]     wgray_next;
    logic [PW-1:0]     rq2;
    logic [PW-1:0]     rbin_s;
    logic [PW-1:0]     level;
    logic [PW-1:0]     full_gray;
    logic [IDX_W-1:0]  last_gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic              found;
    logic [DATA_W-1:0] wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign wdata_arr[i] = wdata_in[i*DATA_W +: DATA_W];
    end

    sync_2ff #(
        .WIDTH(PW)
    ) u_rptr_sync (
        .clk(clk),
        .rst(rst),
        .d  (rptr_gray),
        .q  (rq2)
    );

    // Rotating priority: the search starts one past the last winner and wraps.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        cand_idx = '0;
        found    = 1'b0;
        if (!rst && !wfull) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand_idx = IDX_W'((int'(last_gnt) + k) % NREQ);
                if (!found && req[cand_idx]) begin
                    found   = 1'b1;
                    gnt_idx = cand_idx;
                end
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign mem_we    = found;
    assign mem_waddr = wbin[ADDR_W-1:0];
    assign mem_wdata = wdata_arr[gnt_idx];

    assign wbin_next  = wbin + PW'(mem_we);
    assign wgray_next = PW'(bin2gray(32'(wbin_next)));
    assign rbin_s     = PW'(gray2bin(32'(rq2)));
    assign level      = wbin_next - rbin_s;
    // Full when the write pointer is exactly one lap ahead of the synchronized read pointer.
    assign full_gray  = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            last_gnt     <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
        end else begin
            if (mem_we) begin
                wbin      <= wbin_next;
                wptr_gray <= wgray_next;
                last_gnt  <= gnt_idx;
            end
            wfull        <= (wgray_next == full_gray);
            walmost_full <= (level >= PW'(DEPTH - AFULL_TH));
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Randomized scoreboard bench for the FIFO write-side controller.
module tb_fifo_wr_arbiter_ctrl;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int NREQ     = 4;
    localparam int AFULL_TH = 2;
    localparam int DEPTH    = 16;
    localparam int PMOD     = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] wdata_in = '0;
    logic [3:0]  gnt;
    logic [4:0]  rptr_gray = '0;
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [4:0]  wptr_gray;
    logic        wfull;
    logic        walmost_full;

    fifo_wr_arbiter_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NREQ    (NREQ),
        .AFULL_TH(AFULL_TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .wdata_in    (wdata_in),
        .gnt         (gnt),
        .rptr_gray   (rptr_gray),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wptr_gray   (wptr_gray),
        .wfull       (wfull),
        .walmost_full(walmost_full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [4:0] wgray;
        logic       full;
        logic       afull;
    } st_t;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    st_t st_q[$];
    wr_t wr_q[$];
    int  tests = 0;
    int  fails = 0;

    // Reference model: counts of words written and read, last winner index,
    // and the read counts of the previous two cycles (what the write side can see).
    int m_total = 0;
    int m_w     = 0;
    int m_last  = 0;
    int h1      = 0;
    int h2      = 0;
    bit m_full  = 1'b0;
    bit m_afull = 1'b0;
    int rbin    = 0;

    function automatic logic [4:0] to_gray(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input logic [3:0] rq, input int rb);
        bit   we;
        int   idx;
        int   level;
        st_t  s;
        wr_t  w;
        @(negedge clk);
        rst       = r;
        req       = rq;
        wdata_in  = $urandom;
        rptr_gray = to_gray(rb);
        if (r) begin
            m_total = 0; m_w = 0; m_last = 0; h1 = 0; h2 = 0;
            m_full = 1'b0; m_afull = 1'b0;
            s = '{we: 1'b0, wgray: 5'd0, full: 1'b0, afull: 1'b0};
            st_q.push_back(s);
        end else begin
            we  = 1'b0;
            idx = 0;
            if (!m_full) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_last + k) % NREQ;
                    if (!we && rq[c[1:0]]) begin
                        we  = 1'b1;
                        idx = c;
                    end
                end
            end
            s = '{we: we, wgray: to_gray(m_w), full: m_full, afull: m_afull};
            st_q.push_back(s);
            if (we) begin
                w.gnt  = 4'(1 << idx);
                w.addr = 4'(m_w % DEPTH);
                w.data = 8'(wdata_in >> (idx * DATA_W));
                wr_q.push_back(w);
                m_w     = (m_w + 1) % PMOD;
                m_total = m_total + 1;
                m_last  = idx;
            end
            level   = (m_w - h2 + PMOD) % PMOD;
            m_full  = (level == DEPTH);
            m_afull = (level >= DEPTH - AFULL_TH);
            h2 = h1;
            h1 = rb % PMOD;
        end
    endtask

    // Monitor: compares each cycle's outputs; write expectations are consumed
    // whenever the DUT presents a write strobe.
    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(negedge clk);
            #2;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("mem_we", 32'(mem_we), 32'(s.we));
                chk("wptr_gray", 32'(wptr_gray), 32'(s.wgray));
                chk("wfull", 32'(wfull), 32'(s.full));
                chk("walmost_full", 32'(walmost_full), 32'(s.afull));
                if (mem_we) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", 32'(1), 32'(0));
                    end else begin
                        w = wr_q.pop_front();
                        chk("gnt", 32'(gnt), 32'(w.gnt));
                        chk("mem_waddr", 32'(mem_waddr), 32'(w.addr));
                        chk("mem_wdata", 32'(mem_wdata), 32'(w.data));
                    end
                end else begin
                    chk("gnt_idle", 32'(gnt), 32'(0));
                    if (s.we && wr_q.size() > 0) begin
                        w = wr_q.pop_front();
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] rq;
        int         guard;
        #1 rst = 1'b1;
        // Reset with every producer requesting.
        cycle(1'b1, 4'hF, 0);
        cycle(1'b1, 4'hF, 0);
        // Round-robin and fill: 16 writes, then blocked requests.
        rbin = 0;
        repeat (8)  cycle(1'b0, 4'hF, rbin);
        repeat (11) cycle(1'b0, 4'hF, rbin);
        // One read while full: flag drops, one more write refills.
        rbin = 1;
        repeat (5) cycle(1'b0, 4'hF, rbin);
        // Random traffic with reads never overtaking writes.
        repeat (300) begin
            rq = 4'($urandom);
            if (($urandom % 2) == 1 && rbin < m_total) rbin++;
            cycle(1'b0, rq, rbin);
        end
        // Read pointer trailing the write pointer by 3 across the pointer wrap.
        repeat (40) begin
            rq = 4'($urandom_range(1, 15));
            if (m_total >= 3) rbin = m_total - 3;
            cycle(1'b0, rq, rbin);
        end
        // Reset mid-operation while wbin=9 and requests are active.
        guard = 0;
        while (m_w != 9 && guard < 200) begin
            if (m_total >= 3) rbin = m_total - 3;
            cycle(1'b0, 4'hF, rbin);
            guard++;
        end
        chk("reach_wbin9", 32'(m_w), 32'(9));
        cycle(1'b1, 4'hF, rbin);
        cycle(1'b1, 4'hA, rbin);
        rbin = 0;
        repeat (6) cycle(1'b0, 4'hF, rbin);
        repeat (2) cycle(1'b0, 4'h0, rbin);
        @(negedge clk);
        #4;
        chk("queues_drained", 32'(st_q.size() + wr_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
